// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the MEM pipeline stage: write-back source select and access FSM states.
package mem_stage_ctrl_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_lb.sv
// Byte lane select and sign extension for lb; purely combinational.
module lb_extract (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign data = {{24{byte_sel[7]}}, byte_sel};

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: drives the data-memory req/ack access, stalls upstream while it is outstanding,
// aborts after TIMEOUT unacknowledged cycles and registers the MEM/WB bundle.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic [1:0]  MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_lbflag,
  input  logic [31:0] MEM_out,
  input  logic [31:0] MEM_PC_next,
  input  logic [4:0]  MEM_Write_Register,
  input  logic [31:0] MEM_Write_Data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_Write_Register,
  output logic [31:0] WB_Write_Data,
  output logic        mem_err
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              access;
  logic              misalign;
  logic              abort;
  logic [31:0]       lb_data;
  logic [31:0]       wb_data;
  logic              wb_we;

  assign access   = MEM_MemRead | MEM_MemWrite;
  assign misalign = access & ~MEM_lbflag & (MEM_out[1:0] != 2'b00);
  // Abort cycle drops req so the instruction retires (without writing) this cycle.
  assign abort    = (state == WAIT) && (cnt == CNT_W'(TIMEOUT));

  assign dmem_req   = access & ~misalign & ~abort;
  assign dmem_we    = MEM_MemWrite;
  assign dmem_addr  = {MEM_out[31:2], 2'b00};
  assign dmem_wdata = MEM_Write_Data;
  assign mem_stall  = reset & dmem_req & ~dmem_ack;

  lb_extract u_lb (
    .word   (dmem_rdata),
    .offset (MEM_out[1:0]),
    .data   (lb_data)
  );

  always_comb begin
    wb_data = MEM_out;
    case (MEM_MemtoReg)
      MTR_PC:  wb_data = MEM_PC_next;
      MTR_MEM: wb_data = MEM_lbflag ? lb_data : dmem_rdata;
      default: wb_data = MEM_out;
    endcase
  end

  assign wb_we = MEM_RegWrite & ~misalign & ~abort & (MEM_Write_Register != 5'd0);

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      WB_RegWrite       <= 1'b0;
      WB_Write_Register <= 5'd0;
      WB_Write_Data     <= 32'd0;
      mem_err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (abort || dmem_ack) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      mem_err <= mem_err | misalign | abort;

      // Bubble while stalled so a held load is written exactly once.
      if (mem_stall) begin
        WB_RegWrite       <= 1'b0;
        WB_Write_Register <= 5'd0;
        WB_Write_Data     <= 32'd0;
      end else begin
        WB_RegWrite       <= wb_we;
        WB_Write_Register <= MEM_Write_Register;
        WB_Write_Data     <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a per-instruction reference model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 999;
  localparam int K_ALU = 0, K_LW = 1, K_LB = 2, K_JAL = 3, K_SW = 4;

  logic        sysclk;
  logic        reset;
  logic        MEM_MemWrite, MEM_MemRead, MEM_RegWrite, MEM_lbflag;
  logic [1:0]  MEM_MemtoReg;
  logic [31:0] MEM_out, MEM_PC_next, MEM_Write_Data;
  logic [4:0]  MEM_Write_Register;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, WB_RegWrite, mem_err;
  logic [4:0]  WB_Write_Register;
  logic [31:0] WB_Write_Data;

  int checks = 0;
  int failures = 0;
  logic err_m = 1'b0;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .sysclk(sysclk), .reset(reset),
    .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_lbflag(MEM_lbflag), .MEM_out(MEM_out),
    .MEM_PC_next(MEM_PC_next), .MEM_Write_Register(MEM_Write_Register),
    .MEM_Write_Data(MEM_Write_Data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .WB_RegWrite(WB_RegWrite), .WB_Write_Register(WB_Write_Register),
    .WB_Write_Data(WB_Write_Data), .mem_err(mem_err)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected write-back value straight from the instruction semantics.
  function automatic logic [31:0] model_data(input int kind, input logic [31:0] addr,
                                             input logic [31:0] rdata, input logic [31:0] pcn);
    int b;
    case (kind)
      K_LW:  return rdata;
      K_LB: begin
        b = int'((rdata >> (8 * int'(addr[1:0]))) & 32'hFF);
        return (b < 128) ? 32'(b) : (32'(b) | 32'hFFFF_FF00);
      end
      K_JAL: return pcn;
      default: return addr;
    endcase
  endfunction

  task automatic drive(input int kind, input logic [31:0] addr, input logic [4:0] rd,
                       input logic rw, input logic [31:0] rdata, input logic [31:0] wdata,
                       input logic [31:0] pcn);
    MEM_MemRead        = (kind == K_LW) || (kind == K_LB);
    MEM_MemWrite       = (kind == K_SW);
    MEM_lbflag         = (kind == K_LB);
    MEM_MemtoReg       = (kind == K_LW || kind == K_LB) ? 2'b01 :
                         (kind == K_JAL) ? 2'b10 :
                         ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    MEM_RegWrite       = rw;
    MEM_out            = addr;
    MEM_Write_Register = rd;
    MEM_Write_Data     = wdata;
    MEM_PC_next        = pcn;
    dmem_rdata         = rdata;
    dmem_ack           = 1'b0;
  endtask

  // Presents one instruction and walks it to completion; memory acks 'lat' cycles after req.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [4:0] rd,
                         input logic rw, input logic [31:0] rdata, input logic [31:0] wdata,
                         input logic [31:0] pcn, input int lat);
    logic acc, mis, acc_ok, done, aborted;
    drive(kind, addr, rd, rw, rdata, wdata, pcn);
    acc    = (kind == K_LW) || (kind == K_LB) || (kind == K_SW);
    mis    = acc && (kind != K_LB) && (addr[1:0] != 2'b00);
    acc_ok = acc && !mis;
    done   = 1'b0;
    for (int k = 0; k <= TIMEOUT && !done; k++) begin
      dmem_ack = (k == lat);
      #4;
      done = !acc_ok || (k == lat) || (k == TIMEOUT);
      chk("dmem_req", 32'(dmem_req), 32'(acc_ok && k < TIMEOUT));
      chk("mem_stall", 32'(mem_stall), 32'(!done));
      if (k == 0 && acc_ok) begin
        chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("dmem_we", 32'(dmem_we), 32'(kind == K_SW));
        if (kind == K_SW) chk("dmem_wdata", dmem_wdata, wdata);
      end
      @(posedge sysclk);
      #1;
      dmem_ack = 1'b0;
      if (done) begin
        aborted = acc_ok && (k == TIMEOUT);
        err_m   = err_m | mis | aborted;
        chk("wb_we", 32'(WB_RegWrite), 32'(rw && !mis && !aborted && rd != 5'd0));
        chk("wb_reg", 32'(WB_Write_Register), 32'(rd));
        if (!mis && !aborted) chk("wb_data", WB_Write_Data, model_data(kind, addr, rdata, pcn));
        chk("mem_err", 32'(mem_err), 32'(err_m));
      end else begin
        chk("bubble_we", 32'(WB_RegWrite), 32'd0);
        chk("bubble_data", WB_Write_Data, 32'd0);
      end
    end
    if (!done) chk("txn_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int kind, lat;
    logic [31:0] addr;
    reset = 1'b0;
    drive(K_LW, 32'h40, 5'd3, 1'b1, 32'h1111_2222, 32'h0, 32'h0);
    @(posedge sysclk);
    @(posedge sysclk);
    #4;
    chk("rst_req", 32'(dmem_req), 32'd1);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_we", 32'(WB_RegWrite), 32'd0);
    chk("rst_wb_reg", 32'(WB_Write_Register), 32'd0);
    chk("rst_wb_data", WB_Write_Data, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    @(posedge sysclk);
    #1;
    reset = 1'b1;

    run_txn(K_ALU, 32'h1234, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0, 0);
    run_txn(K_LW, 32'h40, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 3);
    run_txn(K_LB, 32'h43, 5'd8, 1'b1, 32'h8011_2233, 32'h0, 32'h0, 0);
    run_txn(K_LB, 32'h41, 5'd8, 1'b1, 32'h8011_2233, 32'h0, 32'h0, 0);
    run_txn(K_JAL, 32'h99, 5'd31, 1'b1, 32'h0, 32'h0, 32'h0040_0008, 0);
    run_txn(K_JAL, 32'h99, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0040_0008, 0);
    run_txn(K_LW, 32'h42, 5'd9, 1'b1, 32'h5555_AAAA, 32'h0, 32'h0, 0);
    run_txn(K_SW, 32'h80, 5'd0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, NEVER);

    // Reset in the second stalled cycle of a load, then the same load again.
    drive(K_LW, 32'h40, 5'd4, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0);
    #4;
    chk("pre_rst_stall0", 32'(mem_stall), 32'd1);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    #3;
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    @(posedge sysclk);
    #1;
    chk("mid_rst_wb_we", 32'(WB_RegWrite), 32'd0);
    chk("mid_rst_wb_data", WB_Write_Data, 32'd0);
    chk("mid_rst_err", 32'(mem_err), 32'd0);
    err_m = 1'b0;
    reset = 1'b1;
    run_txn(K_LW, 32'h40, 5'd4, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 2);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 4));
      addr = $urandom;
      if (kind != K_LB && kind != K_ALU && $urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      lat = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 4));
      run_txn(kind, addr, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
